gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Global-history (gshare) branch direction predictor: the responder for the ID stage's prediction request (pred_en/pred_pc) and the source of IF's gshare_taken.
- Looks up a pattern history table (PHT) of 2-bit saturating counters indexed by pc XOR speculative global history.
- Keeps the speculative history in step with issued predictions.
- Trains the table and repairs the history from branch-unit resolution in EX.

Parameters:
- HIST_BITS, 8, global history length; PHT has 2^HIST_BITS entries; index width = HIST_BITS.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  pipeline stall; freezes speculative history shift.
- pred_en  in  1  ID holds a conditional branch this cycle.
- pred_pc  in  32  pc of that branch.
- gshare_taken  out  1  combinational prediction to IF (1 = taken).
- pred_index  out  HIST_BITS  combinational lookup index; ID carries it to EX.
- pred_ghr  out  HIST_BITS  current speculative history snapshot; ID carries it to EX.
- upd_en  in  1  EX resolved a conditional branch this cycle.
- upd_index  in  HIST_BITS  pred_index carried with that branch.
- upd_ghr  in  HIST_BITS  pred_ghr carried with that branch.
- upd_taken  in  1  actual outcome.
- upd_failed  in  1  prediction was wrong (same signal as pred_failed to IF).
- busy  out  1  table initialisation in progress.

Behaviour:
- Storage: PHT[2^HIST_BITS] x 2 bits; ghr register (HIST_BITS); init pointer (HIST_BITS); state register.
- FSM states:
  - INIT: reset forces INIT, ghr=0, ptr=0, busy=1. Each INIT cycle writes PHT[ptr]=2'b01 (weakly not-taken) and increments ptr. When ptr==2^HIST_BITS-1, that entry is written and the FSM moves to RUN next cycle. INIT lasts exactly 2^HIST_BITS cycles after reset deasserts.
  - RUN: busy=0. Stays in RUN until reset.
- Reset mid-operation (either state) restarts INIT from ptr=0.
- Outputs during INIT: gshare_taken=0; upd_en/upd_failed ignored; ghr held at 0.
- Lookup (RUN), purely combinational:
  - pred_index = pred_pc[HIST_BITS-1:0] ^ ghr.
  - gshare_taken = pred_en & PHT[pred_index][1].
  - pred_ghr = ghr.
- Speculative history, RUN only, priority top-down:
  - upd_en & upd_failed: ghr <= {upd_ghr[HIST_BITS-2:0], upd_taken}. Any simultaneous pred_en shift is discarded because the pipeline flushes that branch.
  - else pred_en & ~stall: ghr <= {ghr[HIST_BITS-2:0], gshare_taken}.
  - else ghr holds.
- Training, RUN only, upd_en=1: PHT[upd_index] saturating update.
  - upd_taken=1: +1, saturates at 2'b11.
  - upd_taken=0: -1, saturates at 2'b00.
- Read-during-write to the same index: lookup returns the pre-update counter; the new value is visible the next cycle.
- upd_failed with upd_en=0 is ignored.
- Latency:
  - Prediction: 0 cycles (combinational).
  - History shift and counter write: visible 1 cycle later.
- Ordering: updates arrive in program order from a single EX stage; the block does not check this.

Test Plan:
- Reset high 3 cycles, then low with pred_en=1, pred_pc=0x10 → busy=1 and gshare_taken=0 for 256 cycles; busy=0 on cycle 256; gshare_taken=0 (counter 01).
- RUN, ghr=0, pred_en=0: two upd_en with upd_index=0x10, upd_taken=1 → counter 01→10→11. Then pred_en=1, pred_pc=0x10 → gshare_taken=1, pred_index=0x10.
- Counter at 11: four upd_taken=0 updates at 0x10 → 10, 01, 00, 00. Prediction stays 1 after the first update, reads 0 after the second, and does not underflow.
- Speculative shift: ghr=0, PHT[0x10]=11, pred_en=1, pred_pc=0x10, stall=0 → next cycle ghr=0x01; pred_pc=0x10 then gives pred_index=0x11. Repeat with stall=1 → ghr stays 0x00.
- Recovery priority: same cycle pred_en=1 and upd_en=1, upd_failed=1, upd_ghr=0x5A, upd_taken=1 → next cycle ghr=0xB5, not the shifted speculative value.
- Reset asserted mid-RUN with ghr=0x3C and trained entries → ghr=0, busy=1 for 256 cycles, then every entry reads 01 (gshare_taken=0 at all 256 indexes).

Source files
------------

// File: rtl/gshare_predictor.sv
// gshare branch direction predictor: 2-bit counter PHT indexed by pc ^ speculative global history.
// After reset the table self-initialises to weakly-not-taken, one entry per cycle, while busy is high.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | sweeping ptr over the PHT writing 2'b01; predictions forced 0
// RUN   | lookup, speculative history shift, training and repair
module gshare_predictor #(
    parameter int HIST_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 pred_en,
    input  logic [31:0]          pred_pc,
    output logic                 gshare_taken,
    output logic [HIST_BITS-1:0] pred_index,
    output logic [HIST_BITS-1:0] pred_ghr,
    input  logic                 upd_en,
    input  logic [HIST_BITS-1:0] upd_index,
    input  logic [HIST_BITS-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_failed,
    output logic                 busy
);

    localparam int PHT_SIZE = 1 << HIST_BITS;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [HIST_BITS-1:0] ptr_q, ptr_d;
    logic [1:0]           pht_q [PHT_SIZE];
    logic [1:0]           upd_cnt;
    logic [1:0]           upd_cnt_d;
    logic                 run;
    logic                 unused_pc_bits;

    assign run            = (state_q == ST_RUN);
    assign busy           = ~run;
    assign pred_index     = pred_pc[HIST_BITS-1:0] ^ ghr_q;
    assign pred_ghr       = ghr_q;
    assign gshare_taken   = run & pred_en & pht_q[pred_index][1];
    assign unused_pc_bits = ^pred_pc[31:HIST_BITS];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        upd_cnt   = pht_q[upd_index];
        upd_cnt_d = upd_cnt;
        if (upd_taken) begin
            if (upd_cnt != 2'b11) begin
                upd_cnt_d = upd_cnt + 2'd1;
            end
        end else if (upd_cnt != 2'b00) begin
            upd_cnt_d = upd_cnt - 2'd1;
        end
    end

    // A misprediction repair wins over the shift: the branch in ID is being flushed.
    always_comb begin
        ghr_d = ghr_q;
        if (!run) begin
            ghr_d = '0;
        end else if (upd_en && upd_failed) begin
            ghr_d = {upd_ghr[HIST_BITS-2:0], upd_taken};
        end else if (pred_en && !stall) begin
            ghr_d = {ghr_q[HIST_BITS-2:0], gshare_taken};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            ghr_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ghr_q   <= ghr_d;
            ptr_q   <= ptr_d;
        end
    end

    // The table is not reset directly; the INIT sweep rewrites every entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!run) begin
                pht_q[ptr_q] <= 2'b01;
            end else if (upd_en) begin
                pht_q[upd_index] <= upd_cnt_d;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: a driver pushes model expectations per cycle,
// a negedge monitor pops them and compares against the DUT outputs.
module tb_gshare_predictor;

    localparam int HB = 8;
    localparam int N  = 256;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall;
    logic          pred_en;
    logic [31:0]   pred_pc;
    logic          gshare_taken;
    logic [HB-1:0] pred_index;
    logic [HB-1:0] pred_ghr;
    logic          upd_en;
    logic [HB-1:0] upd_index;
    logic [HB-1:0] upd_ghr;
    logic          upd_taken;
    logic          upd_failed;
    logic          busy;

    always #5 clock = ~clock;

    gshare_predictor #(.HIST_BITS(HB)) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .pred_en      (pred_en),
        .pred_pc      (pred_pc),
        .gshare_taken (gshare_taken),
        .pred_index   (pred_index),
        .pred_ghr     (pred_ghr),
        .upd_en       (upd_en),
        .upd_index    (upd_index),
        .upd_ghr      (upd_ghr),
        .upd_taken    (upd_taken),
        .upd_failed   (upd_failed),
        .busy         (busy)
    );

    typedef struct {
        bit check_pred;
        bit busy;
        bit taken;
        int idx;
        int ghr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: counters as ints 0..3, history as an int, init as a countdown.
    int m_pht [N];
    int m_ghr;
    int m_init_left;

    function automatic void chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endfunction

    task automatic cycle(input bit r, input bit st, input bit pe, input logic [31:0] pc,
                         input bit ue, input int ui, input int ug, input bit ut, input bit uf,
                         input int exp_taken = -1, input int exp_idx = -1);
        exp_t e;
        int   idx;
        bit   tk;
        reset      = r;
        stall      = st;
        pred_en    = pe;
        pred_pc    = pc;
        upd_en     = ue;
        upd_index  = HB'(ui);
        upd_ghr    = HB'(ug);
        upd_taken  = ut;
        upd_failed = uf;

        idx = int'(pc % N) ^ m_ghr;
        tk  = (m_init_left == 0) && pe && (m_pht[idx] >= 2);
        e.check_pred = pe;
        e.busy       = (m_init_left != 0);
        e.taken      = tk;
        e.idx        = idx;
        e.ghr        = m_ghr;
        exp_q.push_back(e);

        if (r) begin
            m_init_left = N;
            m_ghr       = 0;
            foreach (m_pht[i]) m_pht[i] = 1;
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else begin
            if (ue) begin
                if (ut) m_pht[ui % N] = (m_pht[ui % N] == 3) ? 3 : m_pht[ui % N] + 1;
                else    m_pht[ui % N] = (m_pht[ui % N] == 0) ? 0 : m_pht[ui % N] - 1;
            end
            if (ue && uf)           m_ghr = ((ug * 2) + int'(ut)) % N;
            else if (pe && !st)     m_ghr = ((m_ghr * 2) + int'(tk)) % N;
        end

        if (exp_taken >= 0 || exp_idx >= 0) begin
            #1;
            if (exp_taken >= 0) chk("dir_taken", int'(gshare_taken), exp_taken);
            if (exp_idx >= 0)   chk("dir_index", int'(pred_index), exp_idx);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares mid-cycle, well away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("busy", int'(busy), int'(e.busy));
                chk("pred_ghr", int'(pred_ghr), e.ghr);
                if (e.check_pred) begin
                    chk("gshare_taken", int'(gshare_taken), int'(e.taken));
                    chk("pred_index", int'(pred_index), e.idx);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        m_init_left = N;
        m_ghr       = 0;
        foreach (m_pht[i]) m_pht[i] = 1;
        reset = 1; stall = 0; pred_en = 0; pred_pc = '0;
        upd_en = 0; upd_index = '0; upd_ghr = '0; upd_taken = 0; upd_failed = 0;
        @(posedge clock);
        #1;

        repeat (3) cycle(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("busy_in_init", int'(busy), 1);
        for (int i = 0; i < N; i++) cycle(0, 0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
        chk("busy_after_init", int'(busy), 0);
        cycle(0, 0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 'h10);
        chk("ghr_after_init", int'(pred_ghr), 0);

        // Train 01 -> 10 -> 11, then predict taken.
        repeat (2) cycle(0, 0, 0, 32'h0, 1, 'h10, 0, 1, 0);
        cycle(0, 1, 1, 32'h10, 0, 0, 0, 0, 0, 1, 'h10);

        // Decrement from 11 with a concurrent lookup seeing the pre-update value.
        for (int k = 0; k < 4; k++) cycle(0, 1, 1, 32'h10, 1, 'h10, 0, 0, 0, (k < 2) ? 1 : 0);
        cycle(0, 1, 1, 32'h10, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 32'h10, 1, 'h10, 0, 1, 0, 0);
        cycle(0, 1, 1, 32'h10, 1, 'h10, 0, 1, 0, 0);
        cycle(0, 1, 1, 32'h10, 1, 'h10, 0, 1, 0, 1);
        cycle(0, 1, 1, 32'h10, 0, 0, 0, 0, 0, 1);

        // Speculative shift, then stall freezing the history.
        cycle(0, 0, 1, 32'h10, 0, 0, 0, 0, 0, 1);
        chk("shift_ghr", int'(pred_ghr), 'h01);
        cycle(0, 1, 1, 32'h10, 0, 0, 0, 0, 0, 0, 'h11);
        cycle(0, 0, 0, 32'h0, 1, 'hFF, 'h00, 0, 1);
        chk("repair_zero_ghr", int'(pred_ghr), 'h00);
        cycle(0, 1, 1, 32'h10, 0, 0, 0, 0, 0, 1, 'h10);
        chk("stall_ghr", int'(pred_ghr), 'h00);

        // Repair outranks the speculative shift in the same cycle.
        cycle(0, 0, 1, 32'h10, 1, 'h33, 'h5A, 1, 1);
        chk("recover_ghr", int'(pred_ghr), 'hB5);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                  int'($urandom_range(0, N - 1)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0));
        end
        while (m_init_left > 0) idle();

        // Mid-run reset with non-zero history and trained entries.
        cycle(0, 0, 0, 32'h0, 1, 'h05, 'h1E, 0, 1);
        chk("ghr_before_reset", int'(pred_ghr), 'h3C);
        repeat (2) cycle(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
        chk("busy_after_reset", int'(busy), 1);
        chk("ghr_after_reset", int'(pred_ghr), 0);
        for (int i = 0; i < N; i++)
            cycle(0, 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)), 1, 1);
        chk("busy_after_reinit", int'(busy), 0);
        for (int i = 0; i < N; i++) cycle(0, 1, 1, 32'(i), 0, 0, 0, 0, 0, 0, i);

        @(negedge clock);
        @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
